multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Sequencing controller for the shared multi-cycle multiply/divide unit used by the execute stage of the 5-stage pipeline.
- Accepts a mult/div instruction from execute and issues a one-cycle start pulse to the unit.
- Freezes the pipeline while the unit works, with a timeout guard.
- Produces a single-cycle register-file write request carrying either the result or the rstatus exception code.

Parameters:
TIMEOUT, 40, WAIT cycles allowed before forced abort (1..255)
STATUS_REG, 30, rstatus register index written on exception
MULT_STATUS, 4, value written to STATUS_REG on mult exception/timeout
DIV_STATUS, 5, value written to STATUS_REG on div exception/timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  execute stage holds a valid instruction
ex_is_mult  in  1  instruction is mul
ex_is_div  in  1  instruction is div
ex_rd  in  5  destination register of instruction
md_ctrl_MULT  out  1  one-cycle start pulse, multiply
md_ctrl_DIV  out  1  one-cycle start pulse, divide
md_result  in  32  unit result
md_exception  in  1  unit exception (overflow / divide by zero), valid with md_resultRDY
md_resultRDY  in  1  unit result valid (single-cycle)
stall  out  1  freeze fetch/decode/execute latches and PC
busy  out  1  state != IDLE
wb_en  out  1  register-file write request
wb_reg  out  5  write register
wb_data  out  32  write data
timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- States: IDLE, START, WAIT, WRITE. 8-bit cycle counter cnt.
- Reset (synchronous, any state): state=IDLE, cnt=0, captured op/rd/result/exc=0, timeout_err=0, all outputs 0.
- Reset mid-operation abandons the op: no writeback, and a later md_resultRDY is ignored.
- IDLE:
  - accept = ex_valid & (ex_is_mult | ex_is_div).
  - If both op flags are set, mult wins.
  - On accept: latch op and ex_rd, go to START.
  - stall is asserted combinationally in the accept cycle; it is 0 otherwise.
- START:
  - Exactly one cycle: md_ctrl_MULT or md_ctrl_DIV = 1 per the latched op.
  - stall=1, cnt<=0, go to WAIT.
  - md_resultRDY is ignored in this state.
- WAIT:
  - stall=1, cnt<=cnt+1.
  - If md_resultRDY: capture md_result and md_exception, go to WRITE.
  - Else if cnt==TIMEOUT-1: capture exc=1, set timeout_err, go to WRITE.
  - If md_resultRDY arrives in the timeout cycle, md_resultRDY wins and timeout_err is not set.
- WRITE:
  - One cycle, stall=0; the pipeline advances past the mult/div at the end of this cycle.
  - ex_* inputs are ignored in this state, so the same instruction is never re-accepted.
  - Exception: wb_en=1, wb_reg=STATUS_REG, wb_data = MULT_STATUS or DIV_STATUS (zero-extended).
  - No exception, rd!=0: wb_en=1, wb_reg=rd, wb_data=result.
  - No exception, rd==0: wb_en=0.
  - Next state: IDLE.
- Outputs:
  - wb_*, md_ctrl_* and busy are registered/state-decoded.
  - stall is combinational: (state==START) | (state==WAIT) | (state==IDLE & accept).
  - wb_reg and wb_data are 0 whenever wb_en=0.
- Latency: accept cycle N → start pulse N+1 → WAIT from N+2. md_resultRDY in cycle K → wb_en in K+1. Stall covers cycles N..K.
- Back-to-back ops: a mult/div entering execute in the cycle after WRITE is accepted normally. There is no overlap; one op in flight at most.

Test Plan:
- mult, rd=7 at cycle 0; unit asserts md_resultRDY with result 14 at cycle 5 → md_ctrl_MULT only at cycle 1; stall=1 for cycles 0..5; wb_en=1, wb_reg=7, wb_data=14 at cycle 6; busy=0 at cycle 7.
- div, rd=11; md_resultRDY with md_exception=1 → wb_reg=30, wb_data=5, single pulse; rd 11 is not written.
- mult, TIMEOUT=40, md_resultRDY never asserted → after 40 WAIT cycles, wb_reg=30, wb_data=4; timeout_err=1 and stays 1 until reset.
- mult, rd=0, result 99, no exception → wb_en stays 0 throughout; busy returns to 0.
- reset asserted in the 3rd WAIT cycle, then md_resultRDY pulses 2 cycles later → all outputs 0 from the next edge; no wb_en; state IDLE.
- ex_is_mult=ex_is_div=1, then a div accepted in the cycle right after WRITE → first op issues md_ctrl_MULT only; second issues md_ctrl_DIV; stall is continuous across the accept cycle with only the WRITE cycle unstalled.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the shared multi-cycle multiply/divide unit.
// Issues a start pulse, stalls the pipeline while the unit works, and emits one writeback.
module multdiv_ctrl #(
  parameter int TIMEOUT     = 40,
  parameter int STATUS_REG  = 30,
  parameter int MULT_STATUS = 4,
  parameter int DIV_STATUS  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_mult,
  input  logic        ex_is_div,
  input  logic [4:0]  ex_rd,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        op_mult;
  logic [4:0]  rd;
  logic [31:0] result;
  logic        exc;
  logic        accept;

  assign accept = ex_valid & (ex_is_mult | ex_is_div);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_mult     <= 1'b0;
      rd          <= '0;
      result      <= '0;
      exc         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_mult <= ex_is_mult;
            rd      <= ex_rd;
            state   <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A result arriving in the timeout cycle takes priority over the abort.
          if (md_resultRDY) begin
            result <= md_result;
            exc    <= md_exception;
            state  <= WRITE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            exc         <= 1'b1;
            timeout_err <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          exc   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they are glitch-free except stall.
  always_comb begin
    md_ctrl_MULT = (state == START) &  op_mult;
    md_ctrl_DIV  = (state == START) & ~op_mult;
    busy         = (state != IDLE);
    stall        = (state == START) | (state == WAIT) | ((state == IDLE) & accept);
    wb_en        = (state == WRITE) & (exc | (rd != '0));
    wb_reg       = '0;
    wb_data      = '0;
    if (wb_en) begin
      if (exc) begin
        wb_reg  = 5'(STATUS_REG);
        wb_data = op_mult ? 32'(MULT_STATUS) : 32'(DIV_STATUS);
      end else begin
        wb_reg  = rd;
        wb_data = result;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus queues expected writebacks, a monitor checks them.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_mult, ex_is_div;
  logic [4:0]  ex_rd;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        stall, busy, wb_en, timeout_err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  multdiv_ctrl #(.TIMEOUT(40), .STATUS_REG(30), .MULT_STATUS(4), .DIV_STATUS(5)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_mult(ex_is_mult),
    .ex_is_div(ex_is_div), .ex_rd(ex_rd), .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY), .stall(stall), .busy(busy), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  wb_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  mult_pulses = 0;
  int  div_pulses = 0;
  int  wb_count = 0;
  bit  armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] r, input logic [31:0] d);
    wb_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected writeback per wb_en pulse, checks zeroed fields otherwise.
  always @(negedge clock) begin
    if (armed) begin
      if (md_ctrl_MULT) mult_pulses++;
      if (md_ctrl_DIV)  div_pulses++;
      if (wb_en) begin
        wb_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_wb_en", 32'(wb_en), 32'd0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_reg", 32'(wb_reg), 32'(e.r));
          check("wb_data", wb_data, e.d);
        end
      end else begin
        check("wb_reg_idle_zero", 32'(wb_reg), 32'd0);
        check("wb_data_idle_zero", wb_data, 32'd0);
      end
    end
  end

  int m0, d0, w0;

  initial begin
    reset = 1'b1; ex_valid = 0; ex_is_mult = 0; ex_is_div = 0; ex_rd = '0;
    md_result = '0; md_exception = 0; md_resultRDY = 0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_wb_en", 32'(wb_en), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_md_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 0);
    reset = 1'b0;
    armed = 1'b1;
    tick();

    // Test 1: mult rd=7, result 14 arrives at cycle 5
    m0 = mult_pulses; d0 = div_pulses; w0 = wb_count;
    tick(); ex_valid = 1; ex_is_mult = 1; ex_rd = 5'd7; expect_wb(5'd7, 32'd14);
    #1 check("t1_stall_c0", 32'(stall), 1);
    tick(); ex_valid = 0; ex_is_mult = 0;
    #1 check("t1_mult_c1", 32'(md_ctrl_MULT), 1);
    check("t1_div_c1", 32'(md_ctrl_DIV), 0);
    check("t1_stall_c1", 32'(stall), 1);
    for (int c = 2; c <= 4; c++) begin
      tick(); #1 check("t1_stall_wait", 32'(stall), 1);
      check("t1_mult_wait", 32'(md_ctrl_MULT), 0);
    end
    tick(); md_resultRDY = 1; md_result = 32'd14;
    #1 check("t1_stall_c5", 32'(stall), 1);
    tick(); md_resultRDY = 0; md_result = '0;
    #1 check("t1_wb_en_c6", 32'(wb_en), 1);
    check("t1_stall_c6", 32'(stall), 0);
    tick(); #1 check("t1_busy_c7", 32'(busy), 0);
    check("t1_mult_pulses", 32'(mult_pulses - m0), 1);
    check("t1_div_pulses", 32'(div_pulses - d0), 0);
    check("t1_wb_count", 32'(wb_count - w0), 1);

    // Test 2: div rd=11 with exception -> rstatus gets DIV_STATUS
    w0 = wb_count; d0 = div_pulses;
    tick(); ex_valid = 1; ex_is_div = 1; ex_rd = 5'd11; expect_wb(5'd30, 32'd5);
    tick(); ex_valid = 0; ex_is_div = 0;
    #1 check("t2_div_pulse", 32'(md_ctrl_DIV), 1);
    tick(); tick(); md_resultRDY = 1; md_exception = 1; md_result = 32'hDEAD;
    tick(); md_resultRDY = 0; md_exception = 0; md_result = '0;
    #1 check("t2_wb_en", 32'(wb_en), 1);
    tick(); tick();
    check("t2_wb_count", 32'(wb_count - w0), 1);
    check("t2_div_pulses", 32'(div_pulses - d0), 1);
    check("t2_timeout_err", 32'(timeout_err), 0);

    // Test 3: mult never answered -> timeout after 40 WAIT cycles
    tick(); ex_valid = 1; ex_is_mult = 1; ex_rd = 5'd3; expect_wb(5'd30, 32'd4);
    tick(); ex_valid = 0; ex_is_mult = 0;
    repeat (40) tick();
    #1 check("t3_stall_last_wait", 32'(stall), 1);
    check("t3_err_before", 32'(timeout_err), 0);
    tick();
    #1 check("t3_wb_en", 32'(wb_en), 1);
    check("t3_err_set", 32'(timeout_err), 1);
    check("t3_stall_write", 32'(stall), 0);
    tick(); tick();
    check("t3_busy_done", 32'(busy), 0);

    // Test 4: mult rd=0, no exception -> no writeback
    w0 = wb_count;
    tick(); ex_valid = 1; ex_is_mult = 1; ex_rd = 5'd0;
    tick(); ex_valid = 0; ex_is_mult = 0;
    tick(); md_resultRDY = 1; md_result = 32'd99;
    tick(); md_resultRDY = 0; md_result = '0;
    #1 check("t4_wb_en", 32'(wb_en), 0);
    check("t4_busy_write", 32'(busy), 1);
    tick(); #1 check("t4_busy_idle", 32'(busy), 0);
    check("t4_wb_count", 32'(wb_count - w0), 0);
    check("t4_err_sticky", 32'(timeout_err), 1);

    // Test 5: reset in 3rd WAIT cycle, late result ignored
    w0 = wb_count;
    tick(); ex_valid = 1; ex_is_mult = 1; ex_rd = 5'd9;
    tick(); ex_valid = 0; ex_is_mult = 0;
    tick(); tick(); tick(); reset = 1;
    tick(); reset = 0;
    #1 check("t5_busy", 32'(busy), 0);
    check("t5_stall", 32'(stall), 0);
    check("t5_err_cleared", 32'(timeout_err), 0);
    check("t5_md_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 0);
    tick(); md_resultRDY = 1; md_result = 32'd77;
    tick(); md_resultRDY = 0; md_result = '0;
    #1 check("t5_wb_en", 32'(wb_en), 0);
    check("t5_busy_after", 32'(busy), 0);
    tick(); check("t5_wb_count", 32'(wb_count - w0), 0);

    // Test 6: both flags -> mult; div offered during WRITE is taken the cycle after
    m0 = mult_pulses; d0 = div_pulses;
    tick(); ex_valid = 1; ex_is_mult = 1; ex_is_div = 1; ex_rd = 5'd5; expect_wb(5'd5, 32'd42);
    #1 check("t6_stall_acc1", 32'(stall), 1);
    tick(); ex_valid = 0; ex_is_mult = 0; ex_is_div = 0;
    #1 check("t6_mult", 32'(md_ctrl_MULT), 1);
    check("t6_no_div", 32'(md_ctrl_DIV), 0);
    tick(); md_resultRDY = 1; md_result = 32'd42;
    tick(); md_resultRDY = 0; md_result = '0; ex_valid = 1; ex_is_div = 1; ex_rd = 5'd6;
    #1 check("t6_stall_write", 32'(stall), 0);
    check("t6_wb_en_write", 32'(wb_en), 1);
    expect_wb(5'd6, 32'd7);
    tick();
    #1 check("t6_stall_acc2", 32'(stall), 1);
    check("t6_no_pulse_acc2", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 0);
    tick(); ex_valid = 0; ex_is_div = 0;
    #1 check("t6_div", 32'(md_ctrl_DIV), 1);
    check("t6_no_mult", 32'(md_ctrl_MULT), 0);
    tick(); md_resultRDY = 1; md_result = 32'd7;
    tick(); md_resultRDY = 0; md_result = '0;
    #1 check("t6_wb_en2", 32'(wb_en), 1);
    tick(); tick();
    check("t6_mult_pulses", 32'(mult_pulses - m0), 1);
    check("t6_div_pulses", 32'(div_pulses - d0), 1);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
